mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports SHALL be named clk and reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  request from the EX stage; sampled only in IDLE.
REQ-006 Funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcA  in  WIDTH  rs1 operand (multiplicand or dividend).
REQ-008 SrcB  in  WIDTH  rs2 operand (multiplier or divisor).
REQ-009 flush  in  1  pipeline flush; aborts any operation.
REQ-010 stall  out  1  freeze request to the IF/ID/EX pipeline registers.
REQ-011 done  out  1  one-cycle pulse; result is valid.
REQ-012 result  out  WIDTH  final value; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-014 IDLE with start=1 and flush=0: latch Funct3; latch |SrcA| and |SrcB| plus sign flags per op signedness (MULHSU: SrcA signed, SrcB unsigned); clear counter and accumulator.
REQ-015 Transition from IDLE: divide with SrcB=0, or signed DIV/REM with SrcA=2^(WIDTH-1) and SrcB=all-ones, goes to DONE directly; otherwise to RUN.
REQ-016 RUN SHALL perform exactly WIDTH iterations, one per cycle: shift-add into a 2*WIDTH product register (multiply) or restoring shift-subtract (divide).
REQ-017 RUN goes to FIX when the counter reaches WIDTH-1; FIX applies sign correction (two's-complement negate) and selects low/high product, quotient or remainder; FIX goes to DONE.
REQ-018 Normal-path latency: done SHALL assert exactly WIDTH+2 cycles after the start-accept edge (34 for WIDTH=32); special-case latency SHALL be 1 cycle.
REQ-019 DONE SHALL assert done for one cycle, then return to IDLE; start SHALL NOT be accepted in the DONE cycle.
REQ-020 stall SHALL be high combinationally in IDLE when start=1 and flush=0, and throughout RUN and FIX; it SHALL be low in DONE and IDLE otherwise.
REQ-021 Sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign; product is negative iff the signs of the signed operands differ.
REQ-022 Division by zero: quotient SHALL be all-ones (DIV and DIVU); remainder SHALL equal SrcA unchanged.
REQ-023 Signed overflow (-2^(WIDTH-1) / -1): quotient SHALL be -2^(WIDTH-1); remainder SHALL be 0.
REQ-024 start while not IDLE SHALL be ignored; SrcA, SrcB and Funct3 changes after accept SHALL NOT affect the result.
REQ-025 flush in any state SHALL force IDLE at the next edge with no done pulse and result unchanged; flush=1 together with start in IDLE SHALL NOT accept.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH on the selected half; no saturation.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and clear counter and accumulator; done=0, stall=0 and result=0; reset SHALL take priority over flush and start.
REQ-028 Reset during RUN SHALL abort without a done pulse; the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-029 MUL SrcA=7, SrcB=6 -> stall high for 34 cycles, single done pulse, result=0x0000002A.
REQ-030 MULH 0x80000000 x 0x80000000 -> result=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-031 DIV 20 / -3 -> result=0xFFFFFFFA; REM 20 / -3 -> result=0x00000002; REM -20 / 3 -> result=0xFFFFFFFE.
REQ-032 DIVU 0x1234 / 0 -> done 1 cycle after accept, result=0xFFFFFFFF; REMU 0x1234 / 0 -> result=0x00001234.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 in 1 cycle; REM of the same operands -> result=0.
REQ-034 MUL start, flush on RUN cycle 10 -> IDLE, no done, stall low next cycle; restart DIVU 100/7 -> result=14 after 34 cycles.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RISC-V M-extension multiply/divide unit that stalls the pipeline
// while a shift-add multiply or restoring divide runs one bit per cycle.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       fsm_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;

  // Handshake: start is a request that is taken only when the FSM is IDLE
  // and flush is low; that same cycle stall rises so EX holds its operands.
  logic             accept;
  logic             in_div, signed_a, signed_b, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_val;

  always_comb begin
    accept   = (state_q == IDLE) && start && !flush;
    in_div   = Funct3[2];
    signed_a = in_div ? !Funct3[0] : (Funct3[1:0] != 2'b11);
    signed_b = in_div ? !Funct3[0] : !Funct3[1];
    neg_a    = signed_a && SrcA[WIDTH-1];
    neg_b    = signed_b && SrcB[WIDTH-1];
    mag_a    = neg_a ? -SrcA : SrcA;
    mag_b    = neg_b ? -SrcB : SrcB;
    div_zero = in_div && (SrcB == '0);
    div_ovf  = in_div && !Funct3[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}})
               && (SrcB == '1);
    special  = div_zero || div_ovf;
    special_val = '0;
    if (div_zero) special_val = Funct3[1] ? SrcA : '1;
    else if (div_ovf) special_val = Funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
  end

  // One iteration of either algorithm; acc holds {high, low} product or
  // {remainder, quotient-with-dividend-shifting-out}.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_ge) div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else        div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed, fix_val;

  always_comb begin
    prod_fixed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fixed  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fixed  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_val    = '0;
    case (op_q)
      3'b000:          fix_val = prod_fixed[WIDTH-1:0];
      3'b001, 3'b010,
      3'b011:          fix_val = prod_fixed[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:  fix_val = quo_fixed;
      default:         fix_val = rem_fixed;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : RUN;
      RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
    stall     = accept || (state_q == RUN) || (state_q == FIX);
    done      = (state_q == DONE);
    result    = result_q;
    fsm_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= Funct3;
        sign_a_q <= neg_a;
        sign_b_q <= neg_b;
        cnt_q    <= '0;
        opnd_q   <= in_div ? mag_b : mag_a;
        acc_q    <= {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
        if (special) result_q <= special_val;
      end else if (state_q == RUN && !flush) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == FIX && !flush) begin
        result_q <= fix_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: driver pushes expected result, latency
// and stall length per accepted op; a negedge monitor pops on each done.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        stall, done;
  logic [31:0] result;
  logic [1:0]  fsm_state;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .flush(flush), .stall(stall),
    .done(done), .result(result), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int stall_cnt = 0;
  int done_seen = 0;
  logic [31:0] last_result = '0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          stall_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sp;
    logic [63:0] up;
    int         ia, ib;
    ia = a;
    ib = b;
    case (f)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'd1: begin sp = longint'(ia) * longint'(ib); up = sp; return up[63:32]; end
      3'd2: begin sp = longint'(ia) * longint'({32'b0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset || flush) stall_cnt = 0;
    else if (stall) stall_cnt++;
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        check("result", 64'(result), 64'(exp_q.pop_front()));
        check("latency", 64'(cyc - accept_cyc + 1), 64'(lat_q.pop_front()));
        check("stall_len", 64'(stall_cnt), 64'(stall_q.pop_front()));
      end
      stall_cnt = 0;
    end
  end

  task automatic wait_done();
    int n = 0;
    int base = done_seen;
    while (done_seen == base && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_seen == base) check("done_timeout", 64'(0), 64'(1));
  endtask

  // Issue one op; returns after the accept edge, inputs scrambled afterwards.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    start = 1'b0;
    Funct3 = 3'($urandom_range(0, 7)); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    bit sp;
    sp = is_special(f, a, b);
    issue(f, a, b);
    exp_q.push_back(e);
    lat_q.push_back(sp ? 1 : 34);
    stall_q.push_back(sp ? 1 : 34);
    if (!sp) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done();
    last_result = e;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b1; flush = 1'b1;
    Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    #1;
    check("idle_stall", 64'(stall), 64'(0));
    check("idle_done", 64'(done), 64'(0));

    do_op(3'd0, 32'd7, 32'd6, 32'h0000_002A);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(3'd4, 32'd20, -32'sd3, 32'hFFFF_FFFA);
    do_op(3'd6, 32'd20, -32'sd3, 32'h0000_0002);
    do_op(3'd6, -32'sd20, 32'd3, 32'hFFFF_FFFE);
    do_op(3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF);
    do_op(3'd7, 32'h1234, 32'h0, 32'h0000_1234);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Flush on the tenth RUN cycle: no done, result untouched.
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_stall", 64'(stall), 64'(0));
    check("flush_result", 64'(result), 64'(last_result));
    repeat (40) @(posedge clk);
    do_op(3'd5, 32'd100, 32'd7, 32'd14);

    // Flush together with start in IDLE must not accept.
    @(posedge clk);
    #1 start = 1'b1; flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check("flush_start_stall", 64'(stall), 64'(0));
    repeat (40) @(posedge clk);

    // Reset in RUN aborts silently and clears result.
    issue(3'd4, 32'd999, 32'd3);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_run_stall", 64'(stall), 64'(0));
    check("rst_run_result", 64'(result), 64'(0));
    repeat (40) @(posedge clk);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, ref_mdu(f, a, b));
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
